// File: rtl/des_pkg.sv
// Shared types and constants for the time-multiplexed DES substitution stage.
package des_pkg;

  localparam int SBOX_CNT   = 8;
  localparam int SBOX_IN_W  = 6;
  localparam int SBOX_OUT_W = 4;
  localparam int DATA_IN_W  = SBOX_CNT * SBOX_IN_W;   // 48
  localparam int DATA_OUT_W = SBOX_CNT * SBOX_OUT_W;  // 32
  localparam int IDX_W      = 3;
  localparam int SBOX_TBL_W = 64 * SBOX_OUT_W;        // 64 entries of 4 bits

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Each table holds the standard four rows of sixteen nibbles, row 0 first,
  // column 0 in the most significant nibble of each row.
  localparam logic [SBOX_TBL_W-1:0] SBOX_TABLE [SBOX_CNT] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  // Row comes from the outer chunk bits, column from the inner four.
  function automatic logic [SBOX_OUT_W-1:0] sbox_lookup(
    input logic [SBOX_TBL_W-1:0] tbl,
    input logic [SBOX_IN_W-1:0]  chunk
  );
    logic [5:0] entry;
    entry = {chunk[5], chunk[0], chunk[4:1]};
    // Entry 0 sits in the top nibble, so the bit offset is (63 - entry) * 4.
    return tbl[{~entry, 2'b00} +: SBOX_OUT_W];
  endfunction

endpackage

// File: rtl/des_sbox.sv
// One DES substitution box; the table contents select which of S1..S8 it is.
module des_sbox
  import des_pkg::*;
#(
  parameter logic [SBOX_TBL_W-1:0] TABLE = '0
) (
  input  logic [SBOX_IN_W-1:0]  chunk,
  output logic [SBOX_OUT_W-1:0] value
);

  assign value = sbox_lookup(TABLE, chunk);

endmodule

// File: rtl/sbox_select.sv
// Shared lookup path: all eight boxes see the same chunk, the index picks one.
module sbox_select
  import des_pkg::*;
(
  input  logic [IDX_W-1:0]      index,
  input  logic [SBOX_IN_W-1:0]  chunk,
  output logic [SBOX_OUT_W-1:0] value
);

  logic [SBOX_OUT_W-1:0] box_out [SBOX_CNT];

  for (genvar g = 0; g < SBOX_CNT; g++) begin : g_box
    des_sbox #(
      .TABLE (SBOX_TABLE[g])
    ) u_box (
      .chunk (chunk),
      .value (box_out[g])
    );
  end

  assign value = box_out[index];

endmodule

// File: rtl/des_sbox_sequencer.sv
// Eight-cycle DES substitution: one 48-bit word in, one 32-bit word out,
// a single S-box lookup per cycle through the shared select path.
module des_sbox_sequencer
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy
);

  state_t                  state;
  state_t                  state_next;
  logic [IDX_W-1:0]        idx;
  logic [IDX_W-1:0]        nib_sel;
  logic [DATA_IN_W-1:0]    shift_q;
  logic [DATA_OUT_W-1:0]   acc_q;
  logic [SBOX_OUT_W-1:0]   sbox_val;
  logic                    accept;
  logic                    step;

  // The chunk for the current box is always at the top of the shift register.
  sbox_select u_sbox_select (
    .index (idx),
    .chunk (shift_q[DATA_IN_W-1 -: SBOX_IN_W]),
    .value (sbox_val)
  );

  assign accept  = (state == IDLE) && in_valid && !clear;
  assign step    = (state == RUN) && !clear;
  // S1 lands in the top nibble, so box k fills nibble 7-k.
  assign nib_sel = 3'd7 - idx;

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values, whatever the block order.
      state <= state_next;
    end
  end

  // Next-state and handshake outputs; clear overrides every other transition.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latch).
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (accept) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (clear)                     state_next = IDLE;
        else if (idx == 3'(SBOX_CNT-1)) state_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (clear || out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: load on accept, then one box per cycle into the accumulator.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      // NOTE: datapath registers are reset too, since out_data must read zero out of reset.
      idx     <= '0;
      shift_q <= '0;
      acc_q   <= '0;
    end else if (clear) begin
      idx <= '0;
    end else if (accept) begin
      shift_q <= in_data;
      idx     <= '0;
    end else if (step) begin
      acc_q[{nib_sel, 2'b00} +: SBOX_OUT_W] <= sbox_val;
      shift_q <= {shift_q[DATA_IN_W-SBOX_IN_W-1:0], {SBOX_IN_W{1'b0}}};
      idx     <= idx + 3'd1;
    end
  end

  // The accumulator persists between words; it is only meaningful in DONE.
  assign out_data = acc_q;

endmodule

// File: tb/tb_des_sbox_sequencer.sv
// Self-checking bench for des_sbox_sequencer: directed scenarios plus a
// scoreboard fed at input handshakes and drained at output handshakes.
module tb_des_sbox_sequencer;

  logic        clk;
  logic        n_rst;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q [$];
  bit          in_flight = 0;

  // Standard DES S-box tables, [box][row][column].
  localparam int SB [8][4][16] = '{
    '{'{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7},
      '{ 0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8},
      '{ 4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0},
      '{15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13}},
    '{'{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10},
      '{ 3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5},
      '{ 0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15},
      '{13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9}},
    '{'{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8},
      '{13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1},
      '{13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7},
      '{ 1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12}},
    '{'{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15},
      '{13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9},
      '{10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4},
      '{ 3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14}},
    '{'{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9},
      '{14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6},
      '{ 4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14},
      '{11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3}},
    '{'{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11},
      '{10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8},
      '{ 9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6},
      '{ 4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13}},
    '{'{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1},
      '{13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6},
      '{ 1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2},
      '{ 6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12}},
    '{'{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7},
      '{ 1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2},
      '{ 7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8},
      '{ 2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}}
  };

  des_sbox_sequencer dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [47:0] w);
    logic [31:0] r;
    logic [5:0]  c;
    int          row;
    int          col;
    r = '0;
    for (int b = 0; b < 8; b++) begin
      c   = w[47 - 6*b -: 6];
      row = {c[5], c[0]};
      col = c[4:1];
      r[31 - 4*b -: 4] = 4'(SB[b][row][col]);
    end
    return r;
  endfunction

  function automatic logic [47:0] rand48();
    logic [63:0] v;
    v = {$urandom(), $urandom()};
    return v[47:0];
  endfunction

  // Scoreboard: push at an accepted input, pop and compare at a consumed output.
  always @(negedge clk) begin
    if (!n_rst) begin
      exp_q.delete();
      in_flight = 0;
    end else if (clear) begin
      if (in_flight) begin
        exp_q.delete(exp_q.size() - 1);
        in_flight = 0;
      end
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_unexpected: got %h with no word pending", out_data);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (out_data !== e) begin
            errors++;
            $display("FAIL scoreboard_data: got %h expected %h", out_data, e);
          end
        end
        in_flight = 0;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_data));
        in_flight = 1;
      end
    end
  end

  // Present one word for exactly one edge; caller ensures the block is idle.
  task automatic drive_word(input logic [47:0] w);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = w;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // One full transaction with out_ready high, checking latency and handshake.
  task automatic run_word(input logic [47:0] w, input logic [31:0] golden,
                          input bit use_golden, input string name);
    out_ready = 1'b1;
    drive_word(w);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL %s_latency: cycle %0d out_valid=%b in_ready=%b busy=%b, required 0/0/1",
                 name, i, out_valid, in_ready, busy);
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_valid: out_valid=%b after 8 cycles, required 1", name, out_valid);
    end
    if (use_golden) begin
      checks++;
      if (out_data !== golden) begin
        errors++;
        $display("FAIL %s_data: got %h expected %h", name, out_data, golden);
      end
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: in_ready=%b out_valid=%b busy=%b, required 1/0/0",
               name, in_ready, out_valid, busy);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: in_ready=%b out_valid=%b out_data=%h busy=%b, required 1/0/0/0",
               in_ready, out_valid, out_data, busy);
    end
  endtask

  task automatic test_known_vectors();
    run_word(48'h0, 32'hEFA72C4D, 1, "zero");
    run_word(48'hFFFF_FFFF_FFFF, 32'hD9CE3DCB, 1, "ones");
    run_word(48'h0000_0084_0000, 32'hEFA7BC4D, 1, "s5_isolation");
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) run_word(rand48(), 32'h0, 0, "random");
  endtask

  task automatic test_backpressure();
    logic [47:0] w;
    logic [31:0] e;
    int          t;
    w = rand48();
    e = model(w);
    out_ready = 1'b0;
    drive_word(w);
    t = 0;
    while (out_valid !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_timeout: out_valid=%b after %0d cycles, required 1", out_valid, t);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== e || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold: cycle %0d out_valid=%b out_data=%h in_ready=%b, required 1/%h/0",
                 i, out_valid, out_data, in_ready, e);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b busy=%b, required 1/0/0",
               in_ready, out_valid, busy);
    end
  endtask

  task automatic test_clear();
    out_ready = 1'b1;
    drive_word(rand48());
    repeat (3) @(posedge clk);
    #1;
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = rand48();
    @(posedge clk); #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clear_idle: in_ready=%b busy=%b out_valid=%b, required 1/0/0",
               in_ready, busy, out_valid);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL clear_no_output: cycle %0d out_valid=%b busy=%b, required 0/0",
                 i, out_valid, busy);
      end
    end
    run_word(48'h0, 32'hEFA72C4D, 1, "after_clear");
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    drive_word(rand48());
    repeat (3) @(posedge clk);
    #1;
    n_rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: in_ready=%b out_valid=%b out_data=%h busy=%b, required 1/0/0/0",
               in_ready, out_valid, out_data, busy);
    end
    @(negedge clk); #2;
    n_rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_output: cycle %0d out_valid=%b busy=%b, required 0/0",
                 i, out_valid, busy);
      end
    end
    run_word(48'h0123_4567_89AB, 32'h0, 0, "after_reset");
  endtask

  task automatic test_back_to_back();
    int accepts;
    int cyc;
    int last;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = rand48();
    accepts  = 0;
    cyc      = 0;
    last     = -1;
    while (accepts < 6 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (in_ready) begin
        if (last >= 0) begin
          checks++;
          if (cyc - last != 10) begin
            errors++;
            $display("FAIL b2b_interval: accept spacing %0d cycles, required 10", cyc - last);
          end
        end
        last = cyc;
        accepts++;
        @(posedge clk); #1;
        if (accepts < 6) in_data = rand48();
        else             in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (accepts != 6) begin
      errors++;
      $display("FAIL b2b_timeout: %0d accepts, required 6", accepts);
    end
    cyc = 0;
    while (in_flight && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (in_flight) begin
      errors++;
      $display("FAIL b2b_drain: last word not returned within 40 cycles");
    end
  endtask

  initial begin
    n_rst     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #12;
    test_reset();
    @(negedge clk); #2;
    n_rst = 1'b1;
    test_known_vectors();
    test_random();
    test_backpressure();
    test_clear();
    test_async_reset();
    test_back_to_back();
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d results still pending, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
